// File: rtl/spi_arb_pkg.sv
// Shared constants, FSM state type and the mode-to-output-enable mapping
// used by the SPI pad arbiter.
package spi_arb_pkg;

  localparam logic [1:0] SPI_MASTER_STD     = 2'd0;
  localparam logic [1:0] SPI_MASTER_QUAD_TX = 2'd1;
  localparam logic [1:0] SPI_MASTER_QUAD_RX = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_GUARD = 2'd2
  } arb_state_e;

  function automatic logic [3:0] oe_for_mode(input logic [1:0] mode);
    case (mode)
      SPI_MASTER_STD:     return 4'b0001;
      SPI_MASTER_QUAD_TX: return 4'b1111;
      default:            return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/spi_arb_rr_pick.sv
// Combinational round-robin pick: first active request after last_owner,
// wrapping modulo NUM_REQ.
module spi_arb_rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last_owner,
  output logic [1:0]         winner,
  output logic               valid
);

  logic [2:0]         shamt;
  logic [NUM_REQ-1:0] rot;
  int                 sum;

  // Bit j of rot is requester (last_owner+1+j) mod NUM_REQ.
  always_comb begin
    shamt  = {1'b0, last_owner} + 3'd1;
    rot    = NUM_REQ'({req, req} >> shamt);
    valid  = |rot;
    winner = '0;
    sum    = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        sum = int'(last_owner) + 1 + j;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        winner = 2'(sum);
      end
    end
  end

endmodule

// File: rtl/spi_pad_arbiter.sv
// Shares one SPI pad set between NUM_REQ masters with round-robin ownership
// and a forced idle guard period between owners.
//   state    | meaning
//   ST_IDLE  | no owner, pads idle, waiting for a request
//   ST_OWN   | one requester drives the pads
//   ST_GUARD | pads idle for GUARD_CYCLES before the next arbitration
module spi_pad_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                    sys_clk,
  input  logic                    ck_rst,
  input  logic [NUM_REQ-1:0]      req_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  input  logic [NUM_REQ-1:0]      rq_clk_i,
  input  logic [NUM_REQ-1:0][3:0] rq_csn_i,
  input  logic [NUM_REQ-1:0][1:0] rq_mode_i,
  input  logic [NUM_REQ-1:0][3:0] rq_sdo_i,
  output logic [NUM_REQ-1:0][3:0] rq_sdi_o,
  output logic                    pad_clk_o,
  output logic [3:0]              pad_csn_o,
  output logic [3:0]              pad_sdo_o,
  output logic [3:0]              pad_oe_o,
  input  logic [3:0]              pad_sdi_i,
  output logic                    busy_o,
  output logic [1:0]              owner_o,
  output logic                    viol_o
);

  localparam logic [7:0] GUARD_LD = 8'(GUARD_CYCLES);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]         owner_q, owner_d, last_q, last_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               pad_clk_q, pad_clk_d, viol_q, viol_d;
  logic [3:0]         pad_csn_q, pad_csn_d, pad_sdo_q, pad_sdo_d, pad_oe_q, pad_oe_d;
  logic [1:0]         pick_winner;
  logic               pick_valid, own_req;

  spi_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (req_i),
    .last_owner (last_q),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  always_comb begin
    own_req = 1'b0;
    viol_d  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner_q == 2'(k)) own_req = req_i[k];
      if (!gnt_q[k] && !(&rq_csn_i[k])) viol_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (pick_valid) begin
          state_d = ST_OWN;
          owner_d = pick_winner;
          last_d  = pick_winner;
          gnt_d   = NUM_REQ'(1) << pick_winner;
        end
      end
      ST_OWN: begin
        if (!own_req) begin
          gnt_d = '0;
          if (GUARD_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GUARD;
            cnt_d   = GUARD_LD;
          end
        end
      end
      ST_GUARD: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Pads follow the next state so the first OWN cycle already carries data
  // and the first GUARD cycle is already idle.
  always_comb begin
    pad_clk_d = 1'b0;
    pad_csn_d = 4'hF;
    pad_sdo_d = 4'h0;
    pad_oe_d  = 4'h0;
    if (state_d == ST_OWN) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (owner_d == 2'(k)) begin
          pad_clk_d = rq_clk_i[k];
          pad_csn_d = rq_csn_i[k];
          pad_sdo_d = rq_sdo_i[k];
          pad_oe_d  = oe_for_mode(rq_mode_i[k]);
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (ck_rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      owner_q   <= 2'd0;
      last_q    <= 2'(NUM_REQ - 1);
      cnt_q     <= 8'd0;
      pad_clk_q <= 1'b0;
      pad_csn_q <= 4'hF;
      pad_sdo_q <= 4'h0;
      pad_oe_q  <= 4'h0;
      viol_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      pad_clk_q <= pad_clk_d;
      pad_csn_q <= pad_csn_d;
      pad_sdo_q <= pad_sdo_d;
      pad_oe_q  <= pad_oe_d;
      viol_q    <= viol_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      rq_sdi_o[k] = gnt_q[k] ? pad_sdi_i : 4'h0;
    end
  end

  assign gnt_o     = gnt_q;
  assign owner_o   = owner_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign pad_clk_o = pad_clk_q;
  assign pad_csn_o = pad_csn_q;
  assign pad_sdo_o = pad_sdo_q;
  assign pad_oe_o  = pad_oe_q;
  assign viol_o    = viol_q;

endmodule

// File: tb/tb_spi_pad_arbiter.sv
// Directed scoreboard bench: dut_a uses a 4-cycle guard, dut_b a zero guard.
module tb_spi_pad_arbiter;
  import spi_arb_pkg::*;

  logic            sys_clk = 1'b0;
  logic            ck_rst;
  logic [1:0]      req, req_b;
  logic [1:0]      rq_clk;
  logic [1:0][3:0] rq_csn, rq_sdo;
  logic [1:0][1:0] rq_mode;
  logic [3:0]      pad_sdi;

  logic [1:0]      gnt_a, gnt_b, owner_a, owner_b;
  logic [1:0][3:0] rq_sdi_a, rq_sdi_b;
  logic            pad_clk_a, pad_clk_b, busy_a, busy_b, viol_a, viol_b;
  logic [3:0]      pad_csn_a, pad_csn_b, pad_sdo_a, pad_sdo_b, pad_oe_a, pad_oe_b;

  spi_pad_arbiter #(.NUM_REQ(2), .GUARD_CYCLES(4)) dut_a (
    .sys_clk(sys_clk), .ck_rst(ck_rst), .req_i(req), .gnt_o(gnt_a),
    .rq_clk_i(rq_clk), .rq_csn_i(rq_csn), .rq_mode_i(rq_mode), .rq_sdo_i(rq_sdo),
    .rq_sdi_o(rq_sdi_a), .pad_clk_o(pad_clk_a), .pad_csn_o(pad_csn_a),
    .pad_sdo_o(pad_sdo_a), .pad_oe_o(pad_oe_a), .pad_sdi_i(pad_sdi),
    .busy_o(busy_a), .owner_o(owner_a), .viol_o(viol_a)
  );

  spi_pad_arbiter #(.NUM_REQ(2), .GUARD_CYCLES(0)) dut_b (
    .sys_clk(sys_clk), .ck_rst(ck_rst), .req_i(req_b), .gnt_o(gnt_b),
    .rq_clk_i(rq_clk), .rq_csn_i(rq_csn), .rq_mode_i(rq_mode), .rq_sdo_i(rq_sdo),
    .rq_sdi_o(rq_sdi_b), .pad_clk_o(pad_clk_b), .pad_csn_o(pad_csn_b),
    .pad_sdo_o(pad_sdo_b), .pad_oe_o(pad_oe_b), .pad_sdi_i(pad_sdi),
    .busy_o(busy_b), .owner_o(owner_b), .viol_o(viol_b)
  );

  always #5 sys_clk = ~sys_clk;

  typedef enum int {
    S_GNT, S_OWNER, S_BUSY, S_CSN, S_OE, S_SDO, S_VIOL, S_CLK, S_SDI, S_GNT_B, S_OWNER_B
  } sel_e;

  typedef struct {
    int          due;
    sel_e        sel;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [31:0] observe(input sel_e sel);
    case (sel)
      S_GNT:     return 32'(gnt_a);
      S_OWNER:   return 32'(owner_a);
      S_BUSY:    return 32'(busy_a);
      S_CSN:     return 32'(pad_csn_a);
      S_OE:      return 32'(pad_oe_a);
      S_SDO:     return 32'(pad_sdo_a);
      S_VIOL:    return 32'(viol_a);
      S_CLK:     return 32'(pad_clk_a);
      S_SDI:     return 32'(rq_sdi_a);
      S_GNT_B:   return 32'(gnt_b);
      S_OWNER_B: return 32'(owner_b);
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Expectations are pushed in non-decreasing due order.
  task automatic expect_at(input int dly, input sel_e sel, input logic [31:0] v, input string tag);
    exp_t e;
    e.due = cyc + dly;
    e.sel = sel;
    e.exp = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk(e.tag, observe(e.sel), e.exp);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ck_rst  = 1'b1;
    req     = 2'b00;
    req_b   = 2'b00;
    rq_clk  = 2'b00;
    rq_csn  = {4'hF, 4'hF};
    rq_sdo  = '0;
    rq_mode = '0;
    pad_sdi = 4'h5;
    step(2);

    expect_at(0, S_GNT, 0, "rst_gnt");
    expect_at(0, S_BUSY, 0, "rst_busy");
    expect_at(0, S_OWNER, 0, "rst_owner");
    expect_at(0, S_CSN, 32'hF, "rst_csn");
    expect_at(0, S_OE, 0, "rst_oe");
    expect_at(0, S_VIOL, 0, "rst_viol");
    ck_rst = 1'b0;
    step(1);

    // Both request after reset: requester 0 wins first.
    req        = 2'b11;
    rq_mode[0] = SPI_MASTER_QUAD_TX;
    expect_at(1, S_GNT, 32'h1, "first_gnt");
    expect_at(1, S_OWNER, 0, "first_owner");
    expect_at(1, S_BUSY, 1, "first_busy");
    expect_at(1, S_CSN, 32'hF, "first_csn");
    expect_at(1, S_OE, 32'hF, "first_oe");
    expect_at(1, S_SDI, 32'h05, "sdi_route0");
    step(1);

    rq_csn[0] = 4'hE;
    rq_sdo[0] = 4'hA;
    rq_clk[0] = 1'b1;
    expect_at(1, S_CSN, 32'hE, "own_csn");
    expect_at(1, S_SDO, 32'hA, "own_sdo");
    expect_at(1, S_CLK, 1, "own_clk");
    expect_at(1, S_VIOL, 0, "own_noviol");
    step(1);

    // Mode walk on the owner.
    rq_mode[0] = SPI_MASTER_QUAD_RX; rq_sdo[0] = 4'h3;
    expect_at(1, S_OE, 32'h0, "oe_quad_rx");
    expect_at(1, S_SDO, 32'h3, "sdo_rx");
    step(1);
    rq_mode[0] = SPI_MASTER_STD; rq_sdo[0] = 4'hC;
    expect_at(1, S_OE, 32'h1, "oe_std");
    expect_at(1, S_SDO, 32'hC, "sdo_std");
    step(1);
    rq_mode[0] = SPI_MASTER_QUAD_TX; rq_sdo[0] = 4'h7;
    expect_at(1, S_OE, 32'hF, "oe_quad_tx");
    expect_at(1, S_SDO, 32'h7, "sdo_tx");
    step(1);

    // Non-owner drives its chip select for three cycles.
    for (int i = 0; i < 3; i++) begin
      rq_csn[1] = 4'b1110;
      expect_at(1, S_VIOL, 1, "viol_pulse");
      expect_at(1, S_CSN, 32'hE, "viol_csn_kept");
      expect_at(1, S_GNT, 32'h1, "no_preempt");
      step(1);
    end
    rq_csn[1] = 4'hF;
    expect_at(1, S_VIOL, 0, "viol_end");
    step(1);

    // Owner 0 releases with requester 1 waiting: guard then grant.
    req       = 2'b10;
    rq_csn[0] = 4'hF;
    rq_sdo[0] = 4'h0;
    rq_clk[0] = 1'b0;
    for (int d = 1; d <= 5; d++) begin
      expect_at(d, S_GNT, 0, "guard_gnt");
      expect_at(d, S_CSN, 32'hF, "guard_csn");
      expect_at(d, S_OE, 0, "guard_oe");
      expect_at(d, S_BUSY, (d <= 4) ? 32'h1 : 32'h0, "guard_busy");
      expect_at(d, S_OWNER, 0, "guard_owner_hold");
    end
    expect_at(6, S_GNT, 32'h2, "guard_next_gnt");
    expect_at(6, S_OWNER, 1, "guard_next_owner");
    expect_at(6, S_SDI, 32'h50, "sdi_route1");
    step(6);

    rq_mode[1] = SPI_MASTER_QUAD_TX;
    rq_csn[1]  = 4'hE;
    expect_at(1, S_CSN, 32'hE, "own1_csn");
    expect_at(1, S_OE, 32'hF, "own1_oe");
    step(1);

    // Reset in the middle of a transfer.
    ck_rst    = 1'b1;
    rq_csn[1] = 4'hF;
    expect_at(1, S_GNT, 0, "rst_mid_gnt");
    expect_at(1, S_CSN, 32'hF, "rst_mid_csn");
    expect_at(1, S_OE, 0, "rst_mid_oe");
    expect_at(1, S_BUSY, 0, "rst_mid_busy");
    expect_at(1, S_OWNER, 0, "rst_mid_owner");
    step(1);
    ck_rst = 1'b0;
    expect_at(1, S_GNT, 32'h2, "post_rst_gnt");
    expect_at(1, S_OWNER, 1, "post_rst_owner");
    step(1);
    req = 2'b00;
    step(2);

    // Zero guard: grants alternate with a two-cycle handover.
    req_b = 2'b11;
    expect_at(1, S_GNT_B, 32'h1, "g0_first_gnt");
    expect_at(1, S_OWNER_B, 0, "g0_first_owner");
    step(1);
    for (int i = 0; i < 3; i++) begin
      automatic int nxt = (i % 2 == 0) ? 1 : 0;
      req_b = 2'(1 << nxt);
      expect_at(1, S_GNT_B, 0, "g0_gap");
      expect_at(2, S_GNT_B, 32'(1 << nxt), "g0_handover");
      expect_at(2, S_OWNER_B, 32'(nxt), "g0_owner");
      step(2);
    end
    req_b = 2'b00;
    step(3);

    chk("sb_drain", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_pad_arbiter.md
SPI_PAD_ARBITER -- requirements
Module: spi_pad_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, giving the number of SPI master requesters (legal 2..4).
REQ-002 The block SHALL have parameter GUARD_CYCLES, default 4, giving the idle cycles forced between ownership changes (legal 0..255).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have these ports, one per line: name  direction  width  meaning.
- sys_clk  in  1  the single clock.
- ck_rst  in  1  synchronous active-high reset.
- req_i  in  NUM_REQ  per-requester bus request, level.
- gnt_o  out  NUM_REQ  one-hot grant, registered.
- rq_clk_i  in  NUM_REQ  requester SPI clock.
- rq_csn_i  in  NUM_REQ x 4  requester chip selects, active-low.
- rq_mode_i  in  NUM_REQ x 2  requester mode: 0 STD, 1 QUAD_TX, 2 QUAD_RX, 3 reserved.
- rq_sdo_i  in  NUM_REQ x 4  requester output data lines.
- rq_sdi_o  out  NUM_REQ x 4  pad input data returned to the requester.
- pad_clk_o  out  1  shared SPI clock pad.
- pad_csn_o  out  4  shared chip-select pads.
- pad_sdo_o  out  4  shared data-out pads.
- pad_oe_o  out  4  per-line output enable for the sdio tri-state.
- pad_sdi_i  in  4  shared sdio pad inputs.
- busy_o  out  1  high in OWN or GUARD.
- owner_o  out  2  index of the current or last owner.
- viol_o  out  1  one-cycle pulse on a protocol violation.

Function
REQ-005 The FSM SHALL have three states: IDLE, OWN and GUARD.
REQ-006 In IDLE with any req_i high, the block SHALL pick a winner round-robin, searching from (last_owner+1) mod NUM_REQ; it SHALL enter OWN and assert gnt_o[winner] on the next edge.
REQ-007 In IDLE with no request, the block SHALL stay in IDLE with gnt_o = 0.
REQ-008 In OWN, the grant SHALL be held while req_i[owner] is high; requests from others SHALL NOT preempt the owner.
REQ-009 In OWN, when req_i[owner] is sampled low, gnt_o SHALL clear on the next edge and the FSM SHALL enter GUARD.
- If GUARD_CYCLES = 0, the FSM SHALL enter IDLE directly instead.
REQ-010 GUARD SHALL last exactly GUARD_CYCLES cycles, counted by an 8-bit down-counter, and then enter IDLE.
- Requests arriving during GUARD SHALL wait.
- The next grant therefore appears GUARD_CYCLES+2 cycles after the owner's req falls.
REQ-011 In OWN, pad_clk_o, pad_csn_o and pad_sdo_o SHALL be registered copies of the owner's inputs, with 1-cycle latency.
REQ-012 In IDLE and GUARD, the pads SHALL be forced idle: pad_csn_o = 4'hF, pad_clk_o = 0, pad_sdo_o = 0, pad_oe_o = 0.
REQ-013 In OWN, pad_oe_o SHALL be registered from the owner's mode:
- STD: 4'b0001.
- QUAD_TX: 4'b1111.
- QUAD_RX: 4'b0000.
- Reserved: 4'b0000.
REQ-014 rq_sdi_o[k] SHALL equal pad_sdi_i combinationally when gnt_o[k] = 1, and 0 otherwise.
REQ-015 viol_o SHALL pulse for one cycle for each cycle in which any non-granted requester drives any rq_csn_i bit low.
- That requester's signals SHALL be ignored.
REQ-016 If the owner's req falls and another req rises in the same cycle, GUARD SHALL still be fully served before the new grant.
REQ-017 owner_o SHALL update on grant and hold its value through GUARD and IDLE.

Reset
REQ-018 While ck_rst = 1 at a clock edge, the block SHALL:
- enter IDLE;
- set gnt_o = 0, busy_o = 0, viol_o = 0, owner_o = 0;
- drive the pads idle as in REQ-012;
- clear the guard counter;
- set last_owner = NUM_REQ-1, so that requester 0 wins first.
REQ-019 Reset asserted in OWN or GUARD SHALL abort the transfer and idle the pads on that same edge; no guard period SHALL be served.

Structure
REQ-020 Mode constants (SPI_MASTER_STD = 0, SPI_MASTER_QUAD_TX = 1, SPI_MASTER_QUAD_RX = 2) and the FSM state enum SHALL live in package spi_arb_pkg.
REQ-021 The round-robin winner selection SHALL be a combinational sub-module named spi_arb_rr_pick (inputs: req vector, last_owner; outputs: winner index, valid).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset then req_i = 2'b11 -> gnt_o = 2'b01 one cycle later, owner_o = 0, busy_o = 1.
- Owner 0 drops req with req1 held high and GUARD_CYCLES = 4 -> pad_csn_o = 4'hF for the guard period, and gnt_o = 2'b10 exactly 6 cycles after req0 fell.
- Owner in QUAD_TX, then QUAD_RX, then STD -> pad_oe_o = 4'hF, then 4'h0, then 4'h1, each 1 cycle after the mode change; pad_sdo_o tracks rq_sdo_i with 1-cycle delay.
- Non-owner drives rq_csn_i = 4'b1110 for 3 cycles -> three viol_o pulses, and pad_csn_o unaffected.
- ck_rst asserted mid-OWN -> next edge gives gnt_o = 0, pads idle, IDLE state; after release with req1 only -> gnt_o = 2'b10.
- GUARD_CYCLES = 0 with back-to-back requests -> the new grant appears 2 cycles after the owner releases, and the owners alternate 0,1,0,1.
